// File: rtl/ntt_pass_sequencer.sv
// Splits a multi-level NTT command into passes of at most LOG_E levels,
// handshaking each pass with the NTT controller via start_NTT / NTT_working.
module ntt_pass_sequencer #(
  parameter int FSIZE      = 64,
  parameter int LOG_N      = 12,
  parameter int LOG_E      = 3,
  parameter int GAP_CYCLES = 2,
  parameter int RISE_TMO   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [FSIZE-1:0]           cmd_p,
  input  logic [$clog2(LOG_N)-1:0]   cmd_start_level,
  input  logic [$clog2(LOG_N+1)-1:0] cmd_num_levels,
  input  logic                       abort,
  output logic                       start_NTT,
  output logic [FSIZE-1:0]           p,
  output logic [$clog2(LOG_E)-1:0]   NTT_levels,
  output logic [$clog2(LOG_N)-1:0]   NTT_base_level,
  input  logic                       NTT_working,
  output logic                       busy,
  output logic [$clog2(LOG_N+1)-1:0] pass_idx,
  output logic                       done,
  output logic                       err
);

  localparam int SW = $clog2(LOG_N);
  localparam int NW = $clog2(LOG_N + 1);
  localparam int LW = $clog2(LOG_E);
  localparam int TW = $clog2(RISE_TMO + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int XW = NW + 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RISE,
    WAIT_FALL,
    GAP,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   cur_q, cur_d;
  logic [NW-1:0]   rem_q, rem_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            abort_q, abort_d;
  logic            errs_q, errs_d;
  logic [FSIZE-1:0] p_q, p_d;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic [SW-1:0]   base_q, base_d;
  logic [NW-1:0]   pidx_q, pidx_d;
  logic            start_q, done_q, err_q, busy_q;
  logic            go_issue;
  logic [XW-1:0]   span;

  assign span = XW'(cmd_start_level) + XW'(cmd_num_levels);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rem_d    = rem_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    abort_d  = abort_q | (abort & (state_q != IDLE));
    errs_d   = errs_q;
    p_d      = p_q;
    lvl_d    = lvl_q;
    base_d   = base_q;
    pidx_d   = pidx_q;
    go_issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          p_d     = cmd_p;
          cur_d   = cmd_start_level;
          rem_d   = cmd_num_levels;
          pidx_d  = '0;
          abort_d = 1'b0;
          errs_d  = 1'b0;
          if (span > XW'(LOG_N)) begin
            errs_d  = 1'b1;
            state_d = DONE;
          end else if (cmd_num_levels == '0) begin
            state_d = DONE;
          end else begin
            go_issue = 1'b1;
          end
        end
      end
      ISSUE: begin
        cur_d   = cur_q + SW'(lvl_q);
        rem_d   = rem_q - NW'(lvl_q);
        tmo_d   = '0;
        state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (NTT_working) begin
          state_d = WAIT_FALL;
        end else if (tmo_q == TW'(RISE_TMO - 1)) begin
          errs_d  = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_FALL: begin
        // an abort arriving with the fall still ends the command here
        if (!NTT_working) begin
          if (rem_q == '0 || abort_d) begin
            state_d = DONE;
          end else if (GAP_CYCLES == 0) begin
            pidx_d   = pidx_q + NW'(1);
            go_issue = 1'b1;
          end else begin
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (abort_d) begin
          state_d = DONE;
        end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
          pidx_d   = pidx_q + NW'(1);
          go_issue = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      DONE: begin
        abort_d = 1'b0;
        errs_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (go_issue) begin
      state_d = ISSUE;
      lvl_d   = (rem_d > NW'(LOG_E)) ? LW'(LOG_E) : LW'(rem_d);
      base_d  = cur_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      abort_q <= 1'b0;
      errs_q  <= 1'b0;
      p_q     <= '0;
      lvl_q   <= '0;
      base_q  <= '0;
      pidx_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
      errs_q  <= errs_d;
      p_q     <= p_d;
      lvl_q   <= lvl_d;
      base_q  <= base_d;
      pidx_q  <= pidx_d;
      start_q <= (state_d == ISSUE);
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == DONE) & (errs_d | abort_d);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign start_NTT      = start_q;
  assign p              = p_q;
  assign NTT_levels     = lvl_q;
  assign NTT_base_level = base_q;
  assign busy           = busy_q;
  assign pass_idx       = pidx_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_ntt_pass_sequencer.sv
// Directed bench for ntt_pass_sequencer with a small NTT controller model.
// Expected pass tables and cycle offsets are written out by hand.
module tb_ntt_pass_sequencer;

  localparam int GAP = 2;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_p = '0;
  logic [3:0]  cmd_start_level = '0;
  logic [3:0]  cmd_num_levels = '0;
  logic        abort = 1'b0;
  logic        start_NTT;
  logic [63:0] p;
  logic [1:0]  NTT_levels;
  logic [3:0]  NTT_base_level;
  logic        NTT_working;
  logic        busy;
  logic [3:0]  pass_idx;
  logic        done;
  logic        err;

  logic mdl_w = 1'b0;
  logic tst_w = 1'b0;
  logic stuck = 1'b0;
  assign NTT_working = mdl_w | tst_w;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_cyc = -100;
  int acc_cyc;
  int d_cyc;
  logic d_err;
  logic [3:0] d_pidx;
  logic [63:0] d_p;
  int sb_base[$], sb_lvl[$], sb_cyc[$], sb_gap[$];
  int exp_b[$], exp_l[$];

  ntt_pass_sequencer #(
    .FSIZE(64), .LOG_N(12), .LOG_E(3),
    .GAP_CYCLES(GAP), .RISE_TMO(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_p(cmd_p),
    .cmd_start_level(cmd_start_level),
    .cmd_num_levels(cmd_num_levels),
    .abort(abort),
    .start_NTT(start_NTT),
    .p(p),
    .NTT_levels(NTT_levels),
    .NTT_base_level(NTT_base_level),
    .NTT_working(NTT_working),
    .busy(busy),
    .pass_idx(pass_idx),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // controller model: rise 2 cycles after start, stay high 3 cycles
  always begin
    @(negedge clk);
    if (start_NTT && !stuck && !rst) begin
      repeat (2) @(negedge clk);
      mdl_w = 1'b1;
      repeat (3) @(negedge clk);
      mdl_w = 1'b0;
      fall_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (start_NTT) begin
      sb_base.push_back(int'(NTT_base_level));
      sb_lvl.push_back(int'(NTT_levels));
      sb_cyc.push_back(cyc);
      sb_gap.push_back(cyc - fall_cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic start_cmd(input logic [3:0] s, input logic [3:0] n,
                           input logic [63:0] pv);
    @(negedge clk);
    sb_base.delete(); sb_lvl.delete();
    sb_cyc.delete(); sb_gap.delete();
    cmd_valid = 1'b1;
    cmd_start_level = s;
    cmd_num_levels = n;
    cmd_p = pv;
    chk("ready_idle", cmd_ready, 1);
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy", busy, 1);
    chk("ready_busy", cmd_ready, 0);
  endtask

  task automatic wait_done();
    d_cyc = -1;
    d_err = 1'b0;
    d_pidx = '0;
    d_p = '0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        d_cyc = cyc;
        d_err = err;
        d_pidx = pass_idx;
        d_p = p;
        break;
      end
      @(negedge clk);
    end
    if (d_cyc < 0) chk("done_seen", 0, 1);
  endtask

  task automatic chk_passes();
    chk("n_start", sb_base.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < sb_base.size(); i++) begin
      chk("base", sb_base[i], exp_b[i]);
      chk("lvls", sb_lvl[i], exp_l[i]);
      if (i > 0) chk("gap", sb_gap[i], GAP + 1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_start", start_NTT, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_p", p, 0);
    chk("rst_lvls", NTT_levels, 0);
    chk("rst_base", NTT_base_level, 0);
    chk("rst_pidx", pass_idx, 0);
    rst = 1'b0;

    // working high while idle must not produce anything
    @(negedge clk);
    tst_w = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_w_busy", busy, 0);
    chk("idle_w_done", done, 0);
    tst_w = 1'b0;

    // full 12-level transform in four passes
    start_cmd(4'd0, 4'd12, 64'h0000_0000_0FFF_F001);
    wait_done();
    exp_b = '{0, 3, 6, 9};
    exp_l = '{3, 3, 3, 3};
    chk_passes();
    if (sb_cyc.size() > 0) chk("latency", sb_cyc[0] - acc_cyc, 1);
    chk("full_err", d_err, 0);
    chk("full_pidx", d_pidx, 3);
    chk("full_p", d_p, 64'h0000_0000_0FFF_F001);

    // out-of-range command
    start_cmd(4'd10, 4'd5, 64'd17);
    wait_done();
    chk("oor_lat", d_cyc - acc_cyc, 1);
    chk("oor_err", d_err, 1);
    chk("oor_nstart", sb_base.size(), 0);

    // zero-level command
    start_cmd(4'd4, 4'd0, 64'd17);
    wait_done();
    chk("zero_lat", d_cyc - acc_cyc, 1);
    chk("zero_err", d_err, 0);
    chk("zero_nstart", sb_base.size(), 0);

    // abort during the second pass
    start_cmd(4'd0, 4'd12, 64'd97);
    for (int i = 0; i < 100 && sb_base.size() < 2; i++) @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done();
    chk("abort_nstart", sb_base.size(), 2);
    chk("abort_err", d_err, 1);
    chk("abort_after_fall", d_cyc - fall_cyc, 1);

    // controller never rises
    stuck = 1'b1;
    start_cmd(4'd0, 4'd3, 64'd5);
    wait_done();
    chk("tmo_nstart", sb_base.size(), 1);
    chk("tmo_err", d_err, 1);
    if (sb_cyc.size() > 0) chk("tmo_lat", d_cyc - (sb_cyc[0] + 1), TMO);
    stuck = 1'b0;

    // async reset while a pass is running
    start_cmd(4'd0, 4'd12, 64'd1234);
    for (int i = 0; i < 50 && !mdl_w; i++) @(negedge clk);
    chk("rst_mid_rise", mdl_w, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rmid_busy", busy, 0);
    chk("rmid_start", start_NTT, 0);
    chk("rmid_done", done, 0);
    chk("rmid_p", p, 0);
    chk("rmid_pidx", pass_idx, 0);
    chk("rmid_base", NTT_base_level, 0);
    chk("rmid_lvls", NTT_levels, 0);
    chk("rmid_ready", cmd_ready, 1);
    for (int i = 0; i < 20 && mdl_w; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // partial transform after reset
    start_cmd(4'd2, 4'd7, 64'd7681);
    wait_done();
    exp_b = '{2, 5, 8};
    exp_l = '{3, 3, 1};
    chk_passes();
    chk("part_err", d_err, 0);
    chk("part_pidx", d_pidx, 2);
    chk("part_p", d_p, 64'd7681);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
